// File: rtl/imul_wb_queue_if.sv
// ----------------------------------------------------------------------------
// imul_wb_queue_if
// Bus bundle between the scheduler/multiplier/writeback port and the
// multiplier writeback queue.
//   issue_en/issue_tag/issue_rdy : op issue into the multiplier, with credit
//   mul_res/mul_flg              : multiplier result and flags {C,O,0,S,Z,P}
//   wb_valid/wb_tag/wb_data/wb_flg/wb_ready : register-file writeback handshake
//   ovf_err                      : sticky dropped-issue indicator
// master : the surroundings (drives issue, multiplier result, wb_ready)
// slave  : the queue itself
// ----------------------------------------------------------------------------
interface imul_wb_queue_if #(
    parameter int TAGW = 9
);
    logic            issue_en;
    logic [TAGW-1:0] issue_tag;
    logic            issue_rdy;
    logic [64:0]     mul_res;
    logic [5:0]      mul_flg;
    logic            wb_valid;
    logic [TAGW-1:0] wb_tag;
    logic [64:0]     wb_data;
    logic [5:0]      wb_flg;
    logic            wb_ready;
    logic            ovf_err;

    modport master (
        output issue_en, issue_tag, mul_res, mul_flg, wb_ready,
        input  issue_rdy, wb_valid, wb_tag, wb_data, wb_flg, ovf_err
    );

    modport slave (
        input  issue_en, issue_tag, mul_res, mul_flg, wb_ready,
        output issue_rdy, wb_valid, wb_tag, wb_data, wb_flg, ovf_err
    );
endinterface

// File: rtl/imul_wb_queue.sv
// ----------------------------------------------------------------------------
// imul_wb_queue
// Writeback stage behind the integer multiplier. Each issued op is tracked
// through a LAT-deep {valid,tag} pipe that advances with i_clk_en, so the
// result is captured in the exact cycle it leaves the multiplier. Results are
// buffered in a DEPTH-entry FIFO and offered to the register-file writeback
// port with valid/ready. Issue credits keep inflight + buffered <= DEPTH.
//
// Ports
//   i_clk     clock
//   i_rst     synchronous reset, active-high
//   i_clk_en  pipeline advance enable (same as the multiplier's)
//   io_bus    imul_wb_queue_if.slave: issue, multiplier result, writeback,
//             ovf_err
//
// Build option
//   IMUL_WB_BYPASS_EN : when defined, a result captured while the FIFO is
//   empty and wb_ready=1 is presented combinationally in the capture cycle
//   and never enters the FIFO. When undefined all wb_* outputs are registered.
// ----------------------------------------------------------------------------
module imul_wb_queue #(
    parameter int LAT   = 3,
    parameter int DEPTH = 4,
    parameter int TAGW  = 9
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic           i_clk_en,
    imul_wb_queue_if.slave io_bus
);
    localparam int PW = $clog2(DEPTH);
    // one spare bit so inflight + count never wraps in the credit compare
    localparam int CW = $clog2(DEPTH + LAT + 1) + 1;
    localparam int EW = TAGW + 65 + 6;

    logic [LAT-1:0]  r_pipe_vld;
    logic [TAGW-1:0] r_pipe_tag [LAT];

    logic [EW-1:0]   r_mem [DEPTH];
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;

    logic            r_wb_valid;
    logic [TAGW-1:0] r_wb_tag;
    logic [64:0]     r_wb_data;
    logic [5:0]      r_wb_flg;
    logic            r_ovf_err;

    logic [CW-1:0]   w_inflight;
    logic [CW-1:0]   w_count_nxt;
    logic            w_issue_rdy;
    logic            w_cap;
    logic            w_bypass;
    logic            w_push;
    logic            w_pop;
    logic [EW-1:0]   w_cap_ent;
    logic [EW-1:0]   w_head_nxt;
    logic [PW-1:0]   w_rd_nxt;

    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < LAT; i++) begin
            w_inflight = w_inflight + CW'(r_pipe_vld[i]);
        end
    end

    // Credit check uses registered state only; a pop returns its credit
    // one cycle later through r_count.
    assign w_issue_rdy = (w_inflight + r_count) < CW'(DEPTH);

    assign w_cap     = i_clk_en & r_pipe_vld[LAT-1];
    assign w_cap_ent = {r_pipe_tag[LAT-1], io_bus.mul_res, io_bus.mul_flg};

`ifdef IMUL_WB_BYPASS_EN
    assign w_bypass = w_cap & (r_count == '0) & io_bus.wb_ready;
`else
    assign w_bypass = 1'b0;
`endif

    assign w_push      = w_cap & ~w_bypass;
    assign w_pop       = r_wb_valid & io_bus.wb_ready;
    assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);
    assign w_rd_nxt    = r_rd_ptr + PW'(w_pop);

    // Next head: if the new read pointer lands on the slot being written this
    // cycle, the entry is not in memory yet, so forward it.
    assign w_head_nxt = (w_push && (w_rd_nxt == r_wr_ptr)) ? w_cap_ent : r_mem[w_rd_nxt];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pipe_vld <= '0;
            for (int i = 0; i < LAT; i++) begin
                r_pipe_tag[i] <= '0;
            end
        end else if (i_clk_en) begin
            r_pipe_vld[0] <= io_bus.issue_en & w_issue_rdy;
            r_pipe_tag[0] <= io_bus.issue_tag;
            for (int i = 1; i < LAT; i++) begin
                r_pipe_vld[i] <= r_pipe_vld[i-1];
                r_pipe_tag[i] <= r_pipe_tag[i-1];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_cap_ent;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_wb_valid <= 1'b0;
            r_wb_tag   <= '0;
            r_wb_data  <= '0;
            r_wb_flg   <= '0;
            r_ovf_err  <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            r_rd_ptr   <= w_rd_nxt;
            r_count    <= w_count_nxt;
            r_wb_valid <= (w_count_nxt != '0);
            // outputs hold the last presented entry once the FIFO drains
            if (w_count_nxt != '0) begin
                {r_wb_tag, r_wb_data, r_wb_flg} <= w_head_nxt;
            end else if (w_bypass) begin
                {r_wb_tag, r_wb_data, r_wb_flg} <= w_cap_ent;
            end
            if (io_bus.issue_en && i_clk_en && !w_issue_rdy) begin
                r_ovf_err <= 1'b1;
            end
        end
    end

    assign io_bus.issue_rdy = w_issue_rdy;
    assign io_bus.ovf_err   = r_ovf_err;

`ifdef IMUL_WB_BYPASS_EN
    assign io_bus.wb_valid = r_wb_valid | w_bypass;
    assign io_bus.wb_tag   = w_bypass ? r_pipe_tag[LAT-1] : r_wb_tag;
    assign io_bus.wb_data  = w_bypass ? io_bus.mul_res    : r_wb_data;
    assign io_bus.wb_flg   = w_bypass ? io_bus.mul_flg    : r_wb_flg;
`else
    assign io_bus.wb_valid = r_wb_valid;
    assign io_bus.wb_tag   = r_wb_tag;
    assign io_bus.wb_data  = r_wb_data;
    assign io_bus.wb_flg   = r_wb_flg;
`endif

endmodule

// File: tb/tb_imul_wb_queue.sv
// ----------------------------------------------------------------------------
// tb_imul_wb_queue
// Directed bench for imul_wb_queue (LAT=3, DEPTH=4, TAGW=9). A small
// multiplier stand-in presents res_of(tag)/flg_of(tag) LAT clkEn-qualified
// cycles after each issue and junk otherwise. Latency expectations follow
// IMUL_WB_BYPASS_EN when that macro is defined for the build.
// ----------------------------------------------------------------------------
module tb_imul_wb_queue;
    localparam int LAT   = 3;
    localparam int DEPTH = 4;
    localparam int TAGW  = 9;
    localparam logic [64:0] JUNK = 65'h0_DEAD_BEEF_DEAD_BEEF;

    logic clk;
    logic rst;
    logic clk_en;

    imul_wb_queue_if #(.TAGW(TAGW)) bus ();

    imul_wb_queue #(.LAT(LAT), .DEPTH(DEPTH), .TAGW(TAGW)) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_clk_en (clk_en),
        .io_bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic [LAT-1:0]  m_vld;
    logic [TAGW-1:0] m_tag [LAT];

    function automatic logic [64:0] res_of(input logic [8:0] t);
        return {1'b1, 55'h0, t} ^ 65'h2F;
    endfunction

    function automatic logic [5:0] flg_of(input logic [8:0] t);
        return t[5:0] ^ 6'h15;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Start of a cycle: apply inputs, drive the multiplier output, settle.
    task automatic step(input logic en, input logic [8:0] tag, input logic ce, input logic rdy);
        bus.issue_en  = en;
        bus.issue_tag = tag;
        clk_en        = ce;
        bus.wb_ready  = rdy;
        if (ce && m_vld[LAT-1]) begin
            bus.mul_res = res_of(m_tag[LAT-1]);
            bus.mul_flg = flg_of(m_tag[LAT-1]);
        end else begin
            bus.mul_res = JUNK;
            bus.mul_flg = 6'h3F;
        end
        #1;
    endtask

    // End of a cycle: clock edge, advance the multiplier stand-in.
    task automatic adv();
        logic ce_s;
        logic en_s;
        logic [8:0] t_s;
        ce_s = clk_en;
        en_s = bus.issue_en;
        t_s  = bus.issue_tag;
        @(posedge clk);
        if (ce_s) begin
            for (int i = LAT - 1; i > 0; i--) begin
                m_vld[i] = m_vld[i-1];
                m_tag[i] = m_tag[i-1];
            end
            m_vld[0] = en_s;
            m_tag[0] = t_s;
        end
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst           = 1'b1;
        clk_en        = 1'b1;
        bus.issue_en  = 1'b0;
        bus.issue_tag = '0;
        bus.wb_ready  = 1'b0;
        bus.mul_res   = JUNK;
        bus.mul_flg   = 6'h3F;
        m_vld         = '0;
        for (int i = 0; i < LAT; i++) m_tag[i] = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // reset state
        step(1'b0, 9'h0, 1'b1, 1'b1);
        chk("rst_wb_valid", bus.wb_valid, 1'b0);
        chk("rst_wb_tag", bus.wb_tag, 9'h0);
        chk("rst_wb_data", bus.wb_data, 65'h0);
        chk("rst_wb_flg", bus.wb_flg, 6'h0);
        chk("rst_issue_rdy", bus.issue_rdy, 1'b1);
        chk("rst_ovf_err", bus.ovf_err, 1'b0);

        // 1: single op, tag 5
        step(1'b1, 9'h05, 1'b1, 1'b1); adv();
        step(1'b0, 9'h0, 1'b1, 1'b1);
        chk("t1_c1_valid", bus.wb_valid, 1'b0);
        adv();
        step(1'b0, 9'h0, 1'b1, 1'b1); adv();
        step(1'b0, 9'h0, 1'b1, 1'b1);
`ifdef IMUL_WB_BYPASS_EN
        chk("t1_c3_valid", bus.wb_valid, 1'b1);
        chk("t1_c3_tag", bus.wb_tag, 9'h05);
        chk("t1_c3_data", bus.wb_data, 65'h1_0000_0000_0000_002A);
        chk("t1_c3_flg", bus.wb_flg, 6'h10);
`else
        chk("t1_c3_valid", bus.wb_valid, 1'b0);
`endif
        adv();
        step(1'b0, 9'h0, 1'b1, 1'b1);
`ifndef IMUL_WB_BYPASS_EN
        chk("t1_c4_valid", bus.wb_valid, 1'b1);
        chk("t1_c4_tag", bus.wb_tag, 9'h05);
        chk("t1_c4_data", bus.wb_data, 65'h1_0000_0000_0000_002A);
        chk("t1_c4_flg", bus.wb_flg, 6'h10);
`else
        chk("t1_c4_valid", bus.wb_valid, 1'b0);
`endif
        adv();
        step(1'b0, 9'h0, 1'b1, 1'b1);
        chk("t1_c5_valid", bus.wb_valid, 1'b0);
        chk("t1_c5_hold", bus.wb_data, 65'h1_0000_0000_0000_002A);
        chk("t1_c5_rdy", bus.issue_rdy, 1'b1);
        adv();

        // 2: fill credits, overflow, drain in order
        for (int k = 1; k <= 4; k++) begin
            step(1'b1, 9'(k), 1'b1, 1'b0);
            chk("t2_rdy_pre", bus.issue_rdy, 1'b1);
            adv();
        end
        step(1'b1, 9'h06, 1'b1, 1'b0);
        chk("t2_rdy_full", bus.issue_rdy, 1'b0);
        chk("t2_ovf_pre", bus.ovf_err, 1'b0);
        adv();
        step(1'b0, 9'h0, 1'b1, 1'b0);
        chk("t2_ovf_set", bus.ovf_err, 1'b1);
        adv();
        step(1'b0, 9'h0, 1'b1, 1'b0); adv();
        step(1'b0, 9'h0, 1'b1, 1'b0);
        chk("t2_full_valid", bus.wb_valid, 1'b1);
        chk("t2_full_tag", bus.wb_tag, 9'h01);
        chk("t2_full_rdy", bus.issue_rdy, 1'b0);
        adv();
        for (int k = 1; k <= 4; k++) begin
            step(1'b0, 9'h0, 1'b1, 1'b1);
            chk("t2_pop_valid", bus.wb_valid, 1'b1);
            chk("t2_pop_tag", bus.wb_tag, 9'(k));
            chk("t2_pop_data", bus.wb_data, res_of(9'(k)));
            chk("t2_pop_flg", bus.wb_flg, flg_of(9'(k)));
            adv();
        end
        step(1'b0, 9'h0, 1'b1, 1'b1);
        chk("t2_end_valid", bus.wb_valid, 1'b0);
        chk("t2_end_rdy", bus.issue_rdy, 1'b1);
        chk("t2_end_ovf", bus.ovf_err, 1'b1);
        adv();

        // 3: tag 7 frozen at the last pipe stage for 5 cycles
        step(1'b1, 9'h07, 1'b1, 1'b1); adv();
        step(1'b0, 9'h0, 1'b1, 1'b1); adv();
        step(1'b0, 9'h0, 1'b1, 1'b1); adv();
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 9'h0, 1'b0, 1'b1);
            chk("t3_frozen_valid", bus.wb_valid, 1'b0);
            adv();
        end
        step(1'b0, 9'h0, 1'b1, 1'b1);
`ifdef IMUL_WB_BYPASS_EN
        chk("t3_cap_valid", bus.wb_valid, 1'b1);
        chk("t3_cap_tag", bus.wb_tag, 9'h07);
        chk("t3_cap_data", bus.wb_data, res_of(9'h07));
`else
        chk("t3_cap_valid", bus.wb_valid, 1'b0);
`endif
        adv();
        step(1'b0, 9'h0, 1'b1, 1'b1);
`ifndef IMUL_WB_BYPASS_EN
        chk("t3_wb_valid", bus.wb_valid, 1'b1);
        chk("t3_wb_tag", bus.wb_tag, 9'h07);
        chk("t3_wb_data", bus.wb_data, res_of(9'h07));
        chk("t3_wb_flg", bus.wb_flg, flg_of(9'h07));
`else
        chk("t3_after_valid", bus.wb_valid, 1'b0);
`endif
        adv();
        for (int k = 0; k < 2; k++) begin
            step(1'b0, 9'h0, 1'b1, 1'b1);
            chk("t3_once_valid", bus.wb_valid, 1'b0);
            adv();
        end

        // 4: count=2, push tag 9 and pop in the same cycle
        step(1'b1, 9'h08, 1'b1, 1'b0); adv();
        step(1'b1, 9'h0A, 1'b1, 1'b0); adv();
        step(1'b1, 9'h09, 1'b1, 1'b0); adv();
        step(1'b0, 9'h0, 1'b1, 1'b0); adv();
        step(1'b0, 9'h0, 1'b1, 1'b0);
        chk("t4_c4_tag", bus.wb_tag, 9'h08);
        adv();
        step(1'b0, 9'h0, 1'b1, 1'b1);
        chk("t4_c5_valid", bus.wb_valid, 1'b1);
        chk("t4_c5_tag", bus.wb_tag, 9'h08);
        adv();
        step(1'b0, 9'h0, 1'b1, 1'b1);
        chk("t4_c6_tag", bus.wb_tag, 9'h0A);
        chk("t4_c6_data", bus.wb_data, res_of(9'h0A));
        chk("t4_c6_rdy", bus.issue_rdy, 1'b1);
        adv();
        step(1'b0, 9'h0, 1'b1, 1'b1);
        chk("t4_c7_valid", bus.wb_valid, 1'b1);
        chk("t4_c7_tag", bus.wb_tag, 9'h09);
        chk("t4_c7_data", bus.wb_data, res_of(9'h09));
        adv();
        step(1'b0, 9'h0, 1'b1, 1'b1);
        chk("t4_c8_valid", bus.wb_valid, 1'b0);
        adv();

        // 5: reset with two ops in flight
        step(1'b1, 9'h11, 1'b1, 1'b1); adv();
        step(1'b1, 9'h12, 1'b1, 1'b1); adv();
        rst = 1'b1;
        step(1'b0, 9'h0, 1'b1, 1'b1); adv();
        rst = 1'b0;
        step(1'b0, 9'h0, 1'b1, 1'b1);
        chk("t5_valid", bus.wb_valid, 1'b0);
        chk("t5_rdy", bus.issue_rdy, 1'b1);
        chk("t5_ovf", bus.ovf_err, 1'b0);
        chk("t5_tag", bus.wb_tag, 9'h0);
        chk("t5_data", bus.wb_data, 65'h0);
        adv();
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 9'h0, 1'b1, 1'b1);
            chk("t5_no_wb", bus.wb_valid, 1'b0);
            adv();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
